// File: rtl/run_detect_sequencer.sv
// Sequencer that clears a run-of-four detector, shifts a test pattern into it bit by bit,
// and gathers the detector's z output into a per-bit hit map and a saturating hit count.
module run_detect_sequencer #(
    parameter int unsigned PAT_W  = 16,
    parameter int unsigned HOLD_W = 8,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [4:0]        len,
    input  logic [HOLD_W-1:0] hold,
    input  logic              det_z,
    output logic              det_w,
    output logic              det_rst_n,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [PAT_W-1:0]  hit_map
);

    localparam int unsigned IDX_W = $clog2(PAT_W);
    localparam int unsigned LEN_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] k_q, k_d;
    logic              clr_q, clr_d;
    logic              det_w_d, det_rst_n_d, busy_d, done_d;
    logic [CNT_W-1:0]  hit_count_d;
    logic [PAT_W-1:0]  hit_map_d;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        k_d         = k_q;
        clr_d       = clr_q;
        hit_count_d = hit_count;
        hit_map_d   = hit_map;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pat_d       = pattern;
                    len_d       = (32'(len) > PAT_W) ? LEN_W'(PAT_W) : LEN_W'(len);
                    hold_d      = (hold < HOLD_W'(3)) ? HOLD_W'(3) : hold;
                    hit_count_d = '0;
                    hit_map_d   = '0;
                    idx_d       = '0;
                    k_d         = '0;
                    clr_d       = 1'b0;
                    state_d     = StClear;
                end
            end
            StClear: begin
                // Second cycle also flushes the detector's stale registered z
                if (clr_q) begin
                    clr_d   = 1'b0;
                    state_d = (len_q != '0) ? StShift : StDone;
                end else begin
                    clr_d = 1'b1;
                end
            end
            StShift: begin
                if (k_q == hold_q - HOLD_W'(1)) begin
                    k_d = '0;
                    if (det_z) begin
                        hit_map_d[idx_q] = 1'b1;
                        if (hit_count != '1) begin
                            hit_count_d = hit_count + CNT_W'(1);
                        end
                    end
                    if (LEN_W'(idx_q) + LEN_W'(1) == len_q) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    k_d = k_q + HOLD_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state
        det_rst_n_d = (state_d != StClear);
        busy_d      = (state_d == StClear) || (state_d == StShift);
        done_d      = (state_d == StDone);
        det_w_d     = (state_d == StShift) && pat_d[idx_d];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            len_q     <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            k_q       <= '0;
            clr_q     <= 1'b0;
            det_w     <= 1'b0;
            det_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit_count <= '0;
            hit_map   <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            k_q       <= k_d;
            clr_q     <= clr_d;
            det_w     <= det_w_d;
            det_rst_n <= det_rst_n_d;
            busy      <= busy_d;
            done      <= done_d;
            hit_count <= hit_count_d;
            hit_map   <= hit_map_d;
        end
    end

endmodule
